// File: rtl/ps2_game_cmd_scheduler.sv
// PS/2 scan byte decoder plus gravity timer, arbitrated into one command FIFO for the game logic.
// Optional AUTO_REPEAT_EN macro adds held-key auto-repeat for LEFT/RIGHT/DOWN.
module ps2_game_cmd_scheduler #(
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 26,
   parameter int GRAV_BASE    = 50000000,
   parameter int GRAV_STEP    = 10000000,
   parameter int REPEAT_DELAY = 15000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] ps2_key_data,
   input  logic       ps2_key_pressed,
   input  logic       game_run,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   output logic [1:0] speed_level,
   output logic [7:0] last_key,
   output logic [7:0] overflow_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int OW = AW + 1;
   localparam logic [2:0] CMD_GRAV = 3'd5;
   localparam logic [CNT_W-1:0] GP0 = CNT_W'(GRAV_BASE - 1);
   localparam logic [CNT_W-1:0] GP1 = CNT_W'(GRAV_BASE - GRAV_STEP - 1);
   localparam logic [CNT_W-1:0] GP2 = CNT_W'(GRAV_BASE - 2 * GRAV_STEP - 1);
   localparam logic [CNT_W-1:0] GP3 = CNT_W'(GRAV_BASE - 3 * GRAV_STEP - 1);

   typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} dec_state_e;

   generate
      if (GRAV_BASE - 3 * GRAV_STEP < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
          FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
         $error("ps2_game_cmd_scheduler: illegal parameter set");
      end
   endgenerate

   function automatic logic [2:0] key_cmd(input logic [7:0] code);
      case (code)
         8'h1B:   key_cmd = 3'd1;
         8'h2B:   key_cmd = 3'd2;
         8'h24:   key_cmd = 3'd3;
         8'h23:   key_cmd = 3'd4;
         default: key_cmd = 3'd0;
      endcase
   endfunction

   dec_state_e       state_q, state_d;
   logic             make_v;
   logic [2:0]       make_cmd, key_cmd_w;
   logic [1:0]       speed_q, speed_d;
   logic [7:0]       last_key_q, last_key_d;
   logic             spd_chg;
   logic [CNT_W-1:0] grav_cnt_q, grav_cnt_d, period_m1;
   logic             grav_tick, pending_q, pending_d;
   logic             key_push, grav_wr, wr_en, pop, full, push_ok, drop;
   logic [2:0]       wr_data;
   logic [2:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [OW-1:0]    count_q, count_d;
   logic [7:0]       ovf_q, ovf_d;

   // Only a byte seen in IDLE is a make code; prefixes steer the FSM instead.
   always_comb begin : decode
      state_d = state_q;
      make_v  = 1'b0;
      if (ps2_key_pressed) begin
         case (state_q)
            S_IDLE: begin
               if (ps2_key_data == 8'hF0)      state_d = S_BRK;
               else if (ps2_key_data == 8'hE0) state_d = S_EXT;
               else                            make_v  = 1'b1;
            end
            S_BRK:   state_d = S_IDLE;
            S_EXT:   state_d = (ps2_key_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign make_cmd = make_v ? key_cmd(ps2_key_data) : 3'd0;

   always_comb begin : speed_ctl
      speed_d    = speed_q;
      last_key_d = last_key_q;
      if (make_v) begin
         if (make_cmd != 3'd0) last_key_d = ps2_key_data;
         if (ps2_key_data == 8'h3A) begin
            last_key_d = ps2_key_data;
            if (speed_q != 2'd0) speed_d = speed_q - 2'd1;
         end
         if (ps2_key_data == 8'h44) begin
            last_key_d = ps2_key_data;
            if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
         end
      end
   end

   assign spd_chg = (speed_d != speed_q);

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] RD_M1 = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_M1 = CNT_W'(REPEAT_RATE - 1);
   logic [2:0]       held_q, held_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_first_q, rep_first_d;
   logic             brk_v, rep_push;

   assign brk_v    = ps2_key_pressed && (state_q == S_BRK);
   assign rep_push = (held_q != 3'd0) && (rep_cnt_q == (rep_first_q ? RD_M1 : RR_M1));

   always_comb begin : repeat_ctl
      held_d      = held_q;
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      if (make_cmd == 3'd1 || make_cmd == 3'd2 || make_cmd == 3'd4) begin
         held_d      = make_cmd;
         rep_cnt_d   = '0;
         rep_first_d = 1'b1;
      end else if (brk_v && held_q != 3'd0 && key_cmd(ps2_key_data) == held_q) begin
         held_d    = 3'd0;
         rep_cnt_d = '0;
      end else if (held_q != 3'd0) begin
         if (rep_push) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
         end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
         end
      end
   end

   assign key_cmd_w = (make_cmd != 3'd0) ? make_cmd : (rep_push ? held_q : 3'd0);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         held_q      <= 3'd0;
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b0;
      end else begin
         held_q      <= held_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
      end
   end
`else
   assign key_cmd_w = make_cmd;
`endif

   always_comb begin : period_sel
      case (speed_q)
         2'd0:    period_m1 = GP0;
         2'd1:    period_m1 = GP1;
         2'd2:    period_m1 = GP2;
         default: period_m1 = GP3;
      endcase
   end

   assign grav_tick  = game_run && (grav_cnt_q == period_m1);
   assign grav_cnt_d = (!game_run || spd_chg || grav_tick) ? '0 : grav_cnt_q + CNT_W'(1);

   // Keys win the single write port; a pending tick waits rather than being dropped.
   assign key_push = (key_cmd_w != 3'd0);
   assign grav_wr  = game_run && pending_q && !key_push;
   assign wr_en    = key_push || grav_wr;
   assign wr_data  = key_push ? key_cmd_w : CMD_GRAV;
   assign pop      = cmd_valid && cmd_ready;
   assign full     = (count_q == OW'(FIFO_DEPTH));
   assign push_ok  = wr_en && (!full || pop);
   assign drop     = key_push && !push_ok;

   always_comb begin : pending_ctl
      pending_d = 1'b0;
      if (game_run) begin
         pending_d = pending_q;
         if (grav_wr && push_ok) pending_d = 1'b0;
         if (grav_tick)          pending_d = 1'b1;
      end
   end

   assign ovf_d = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;

   always_comb begin : occupancy
      case ({push_ok, pop})
         2'b10:   count_d = count_q + OW'(1);
         2'b01:   count_d = count_q - OW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         speed_q    <= 2'd0;
         last_key_q <= 8'd0;
         grav_cnt_q <= '0;
         pending_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         speed_q    <= speed_d;
         last_key_q <= last_key_d;
         grav_cnt_q <= grav_cnt_d;
         pending_q  <= pending_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign cmd_valid    = (count_q != '0);
   assign cmd_code     = cmd_valid ? mem_q[rd_ptr_q] : 3'd0;
   assign speed_level  = speed_q;
   assign last_key     = last_key_q;
   assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_ps2_game_cmd_scheduler.sv
// Scoreboard bench for ps2_game_cmd_scheduler: expected commands queued at stimulus time,
// compared as the consumer pops them; gravity and auto-repeat timing measured in clock cycles.
module tb_ps2_game_cmd_scheduler;
   logic       clock = 1'b0;
   logic       resetn;
   logic [7:0] ps2_key_data;
   logic       ps2_key_pressed;
   logic       game_run;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic [1:0] speed_level;
   logic [7:0] last_key;
   logic [7:0] overflow_cnt;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         grav_cyc = 0;
   int         s;
   int         t;
   int         down_cyc[$];
   logic [2:0] exp_q[$];
   logic [2:0] e;

   ps2_game_cmd_scheduler #(
      .FIFO_DEPTH(4), .CNT_W(26), .GRAV_BASE(40), .GRAV_STEP(10),
      .REPEAT_DELAY(8), .REPEAT_RATE(4)
   ) dut (
      .clock(clock), .resetn(resetn), .ps2_key_data(ps2_key_data),
      .ps2_key_pressed(ps2_key_pressed), .game_run(game_run), .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .speed_level(speed_level),
      .last_key(last_key), .overflow_cnt(overflow_cnt)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Consumer side: each accepted command must match the head of the expected queue.
   always @(negedge clock) begin
      if (resetn && cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_cmd", 32'(cmd_code), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("cmd_code", 32'(cmd_code), 32'(e));
         end
         if (cmd_code == 3'd5) grav_cyc = cyc;
         if (cmd_code == 3'd4) down_cyc.push_back(cyc);
      end
   end

   // All drivers run at posedge+1; a byte driven here is sampled on the next edge.
   task automatic send_byte(input logic [7:0] b);
      ps2_key_data    = b;
      ps2_key_pressed = 1'b1;
      @(posedge clock); #1;
      ps2_key_pressed = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic wait_until(input int c);
      int n = 0;
      while (cyc < c && n < 500) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      cmd_ready = 1'b1;
      while ((exp_q.size() != 0 || cmd_valid) && n < 60) begin
         @(posedge clock); #1;
         n++;
      end
      check_eq(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_grav(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check_eq(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 1'b0; ps2_key_data = 8'd0; ps2_key_pressed = 1'b0;
      game_run = 1'b0; cmd_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_eq("rst_valid", 32'(cmd_valid), 32'd0);
      check_eq("rst_code", 32'(cmd_code), 32'd0);
      check_eq("rst_speed", 32'(speed_level), 32'd0);
      check_eq("rst_last_key", 32'(last_key), 32'd0);
      check_eq("rst_ovf", 32'(overflow_cnt), 32'd0);
      @(posedge clock); #1;
      resetn = 1'b1;
      step(2);

      // Reset / latency: entry visible the cycle after the strobe, never the same cycle.
      ps2_key_data = 8'h1B; ps2_key_pressed = 1'b1;
      exp_q.push_back(3'd1);
      @(negedge clock);
      check_eq("no_bypass", 32'(cmd_valid), 32'd0);
      @(posedge clock); #1;
      ps2_key_pressed = 1'b0;
      check_eq("lat_valid", 32'(cmd_valid), 32'd1);
      check_eq("lat_code", 32'(cmd_code), 32'd1);
      check_eq("lat_last_key", 32'(last_key), 32'h1B);
      drain("drain_t1");
      cmd_ready = 1'b0;

      // Break and extended sequences must not push nor update last_key.
      send_byte(8'hF0); send_byte(8'h1B);
      send_byte(8'hE0); send_byte(8'h6B);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
      send_byte(8'hE0); send_byte(8'h2B);
      step(3);
      check_eq("filter_valid", 32'(cmd_valid), 32'd0);
      check_eq("filter_last_key", 32'(last_key), 32'h1B);
      send_byte(8'h2B);
      exp_q.push_back(3'd2);
      check_eq("idle_after_ext", 32'(cmd_code), 32'd2);
      drain("drain_t2");
      // Reset in the middle of a break sequence returns the decoder to IDLE.
      send_byte(8'hF0);
      resetn = 1'b0;
      step(1);
      resetn = 1'b1;
      step(1);
      send_byte(8'h1B);
      exp_q.push_back(3'd1);
      check_eq("mid_rst_last_key", 32'(last_key), 32'h1B);
      drain("drain_rst");
      cmd_ready = 1'b0;

      // Overflow: four accepted, two dropped; push with same-cycle pop at full is accepted.
      for (int i = 0; i < 6; i++) begin
         send_byte(8'h2B);
         if (i < 4) exp_q.push_back(3'd2);
      end
      check_eq("full_ovf", 32'(overflow_cnt), 32'd2);
      ps2_key_data = 8'h2B; ps2_key_pressed = 1'b1; cmd_ready = 1'b1;
      exp_q.push_back(3'd2);
      @(posedge clock); #1;
      ps2_key_pressed = 1'b0;
      check_eq("pop_push_ovf", 32'(overflow_cnt), 32'd2);
      drain("drain_t3");

      // Gravity at speed 0 (period 40), then a key on the cycle the tick would be written.
      s = cyc;
      game_run = 1'b1;
      exp_q.push_back(3'd5);
      wait_grav("grav1_seen");
      check_eq("grav1_time", 32'(grav_cyc - s), 32'd41);
      exp_q.push_back(3'd5);
      wait_grav("grav2_seen");
      check_eq("grav2_time", 32'(grav_cyc - s), 32'd81);
      wait_until(s + 120);
      ps2_key_data = 8'h2B; ps2_key_pressed = 1'b1;
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd5);
      @(posedge clock); #1;
      ps2_key_pressed = 1'b0;
      wait_grav("grav3_seen");
      check_eq("grav_after_key", 32'(grav_cyc - s), 32'd122);
      game_run = 1'b0;
      step(2);

      // Speed control with saturation; counter restarts on a change.
      send_byte(8'h44);
      check_eq("speed_up1", 32'(speed_level), 32'd1);
      for (int i = 0; i < 3; i++) send_byte(8'h44);
      check_eq("speed_sat3", 32'(speed_level), 32'd3);
      check_eq("speed_last_key", 32'(last_key), 32'h44);
      s = cyc;
      game_run = 1'b1;
      exp_q.push_back(3'd5);
      wait_grav("fast_seen");
      check_eq("fast_time", 32'(grav_cyc - s), 32'd11);
      wait_until(s + 14);
      send_byte(8'h3A);
      exp_q.push_back(3'd5);
      wait_grav("restart_seen");
      check_eq("restart_time", 32'(grav_cyc - s), 32'd36);
      check_eq("speed_dn2", 32'(speed_level), 32'd2);
      game_run = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'h3A);
      check_eq("speed_sat0", 32'(speed_level), 32'd0);
      check_eq("speed_dn_last_key", 32'(last_key), 32'h3A);
      step(2);

      // Held DOWN: auto-repeat when enabled, otherwise a single command.
      down_cyc.delete();
      t = cyc + 1;
      send_byte(8'h23);
`ifdef AUTO_REPEAT_EN
      for (int i = 0; i < 4; i++) exp_q.push_back(3'd4);
`else
      exp_q.push_back(3'd4);
`endif
      wait_until(t + 16);
      send_byte(8'hF0);
      send_byte(8'h23);
      step(30);
      check_eq("down_all_seen", 32'(exp_q.size()), 32'd0);
`ifdef AUTO_REPEAT_EN
      check_eq("repeat_count", 32'(down_cyc.size()), 32'd4);
      for (int i = 0; i < down_cyc.size() && i < 4; i++)
         check_eq("repeat_time", 32'(down_cyc[i] - t), (i == 0) ? 32'd0 : 32'(4 + 4 * i));
`else
      check_eq("down_count", 32'(down_cyc.size()), 32'd1);
      if (down_cyc.size() > 0) check_eq("down_time", 32'(down_cyc[0] - t), 32'd0);
`endif
      check_eq("final_ovf", 32'(overflow_cnt), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
